game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow controller for the Tetris datapath, clocked by a single clock.
//  - Sequences piece spawn: pulses the rng block and latches its 2-bit selection.
//  - Issues periodic fall steps to the fall unit using a req/ack handshake.
//  - Scans the 32-bit board_status for full rows, commands row clears and counts cleared lines.
//  - Detects game over.
// PARAMETERS
//  ROWS      8    board rows; row 0 is the top row
//  COLS      4    board columns; ROWS*COLS must equal 32
//  TICK_DIV  16   clka cycles spent in WAIT_TICK between fall steps (>=2)
// PORTS
//  clka          in   1   single clock; all state updates on the falling edge
//  restart       in   1   asynchronous, active-high reset
//  start         in   1   begin a game; sampled only in IDLE
//  board_status  in   32  locked cells; row r = bits [r*COLS +: COLS]
//  piece_sel     in   2   current rng piece selection
//  fall_ack      in   1   fall unit finished the requested step
//  landed        in   1   qualified by fall_ack: 1 = piece could not move and is now locked
//  new_piece     out  1   1-cycle pulse: advance the rng
//  spawn_en      out  1   1-cycle pulse: place spawn_piece at the top
//  spawn_piece   out  2   piece to spawn; valid while spawn_en=1
//  fall_req      out  1   level: request one fall step
//  clear_en      out  1   1-cycle pulse: delete row clear_row and shift the rows above it down
//  clear_row     out  3   row index to clear (log2 ROWS bits)
//  lines         out  8   cleared-line count; saturates at 255
//  busy          out  1   1 in every state except IDLE and OVER
//  game_over     out  1   1 while in OVER
// BEHAVIOUR
//  - All outputs are registered. Every pulse lasts exactly one clka cycle.
//  - restart=1 (async, any time, including mid-handshake):
//    - state=IDLE; tick counter=0; scan row=ROWS-1; lines=0.
//    - All outputs are 0. fall_req drops immediately.
//  - IDLE: start=1 -> SPAWN and lines <= 0.
//  - start is ignored in every state other than IDLE.
//  - SPAWN (1 cycle):
//    - If the top row board_status[COLS-1:0] != 0 -> OVER; no spawn pulse is issued.
//    - Otherwise, on the same edge: spawn_en=1, new_piece=1, spawn_piece=piece_sel, tick counter=0, then -> WAIT_TICK.
//  - WAIT_TICK:
//    - On each edge, if counter==TICK_DIV-1 then counter<=0, fall_req<=1 and state -> FALL.
//    - Otherwise counter++.
//  - FALL: fall_req holds 1 until fall_ack=1 is sampled. On that edge fall_req<=0, then:
//    - landed=0 -> WAIT_TICK.
//    - landed=1 -> SCAN with scan row=ROWS-1 (bottom row).
//    - fall_ack sampled while fall_req=0 is ignored.
//  - SCAN: examines one row per cycle.
//    - Row all ones -> CLEAR.
//    - Row not full and row==0 -> SPAWN.
//    - Row not full and row>0 -> row--.
//  - CLEAR (1 cycle): clear_en=1, clear_row=row, lines=min(lines+1,255), then -> SCAN at the SAME row.
//    - Rows above have shifted down, so that row is re-examined.
//    - The datapath must update board_status before the next edge.
//  - OVER: game_over=1, busy=0, all pulses 0. The only exit is restart.
//  - Latency:
//    - start sampled at edge k -> spawn_en/new_piece valid from edge k+1 to k+2.
//    - First fall_req rises at edge k+1+TICK_DIV.
//  - Multiple full rows are cleared one at a time, bottom first.
//  - A full top row is cleared in SCAN before the next SPAWN game-over check.
// TESTING
//  - TICK_DIV=4, empty board, start pulse at edge 0:
//    -> spawn_en=1 after edge 1 with spawn_piece=piece_sel.
//    -> fall_req rises after edge 5.
//  - fall_req high and fall_ack withheld for 10 cycles:
//    -> fall_req held high and state unchanged.
//    -> ack with landed=0 -> fall_req=0, next fall_req 4 cycles later.
//  - ack with landed=1, board rows 7 and 6 = 4'hF, datapath shifts rows on clear_en:
//    -> two clear_en pulses, both with clear_row=7.
//    -> lines=2, then a SPAWN pulse.
//  - Top row 4'b0100 at SPAWN -> game_over=1, busy=0, no spawn_en.
//    - start is then ignored.
//    - restart -> IDLE with all outputs 0.
//  - restart asserted mid-FALL with fall_req=1:
//    -> fall_req=0 immediately (asynchronous), lines=0.
//  - 256 forced clears -> lines saturates at 8'hFF.

Source files
------------

// File: rtl/game_sequencer.sv
// Tetris game-flow controller: spawn, timed fall steps (req/ack), row-full scan/clear, line count, game over.
// State changes on the falling clka edge; pulses last one cycle; fall_req holds until the fall unit acks.
module game_sequencer #(
  parameter int ROWS     = 8,
  parameter int COLS     = 4,
  parameter int TICK_DIV = 16
) (
  input  logic                     clka,
  input  logic                     restart,
  input  logic                     start,
  input  logic [ROWS*COLS-1:0]     board_status,
  input  logic [1:0]               piece_sel,
  input  logic                     fall_ack,
  input  logic                     landed,
  output logic                     new_piece,
  output logic                     spawn_en,
  output logic [1:0]               spawn_piece,
  output logic                     fall_req,
  output logic                     clear_en,
  output logic [$clog2(ROWS)-1:0]  clear_row,
  output logic [7:0]               lines,
  output logic                     busy,
  output logic                     game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_SCAN  = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] tick_cnt;
  logic [RW-1:0] scan_row;
  logic          row_full;
  logic          top_row_occ;

  always_comb begin
    row_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (scan_row == RW'(r)) begin
        row_full = &board_status[r*COLS +: COLS];
      end
    end
  end

  assign top_row_occ = |board_status[COLS-1:0];

  always_ff @(negedge clka or posedge restart) begin
    if (restart) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      scan_row    <= ROW_LAST;
      lines       <= 8'd0;
      new_piece   <= 1'b0;
      spawn_en    <= 1'b0;
      spawn_piece <= 2'd0;
      fall_req    <= 1'b0;
      clear_en    <= 1'b0;
      clear_row   <= '0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      new_piece <= 1'b0;
      spawn_en  <= 1'b0;
      clear_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SPAWN;
            lines <= 8'd0;
            busy  <= 1'b1;
          end
        end
        S_SPAWN: begin
          // An occupied top row means the new piece has nowhere to go.
          if (top_row_occ) begin
            state     <= S_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            spawn_en    <= 1'b1;
            new_piece   <= 1'b1;
            spawn_piece <= piece_sel;
            tick_cnt    <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            fall_req <= 1'b1;
            state    <= S_FALL;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_FALL: begin
          if (fall_ack) begin
            fall_req <= 1'b0;
            if (landed) begin
              scan_row <= ROW_LAST;
              state    <= S_SCAN;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_SCAN: begin
          if (row_full) begin
            state <= S_CLEAR;
          end else if (scan_row == '0) begin
            state <= S_SPAWN;
          end else begin
            scan_row <= scan_row - 1'b1;
          end
        end
        S_CLEAR: begin
          // scan_row is kept: the rows above drop into it and must be re-examined.
          clear_en  <= 1'b1;
          clear_row <= scan_row;
          if (lines != 8'hFF) begin
            lines <= lines + 8'd1;
          end
          state <= S_SCAN;
        end
        S_OVER: begin
          busy      <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          fall_req  <= 1'b0;
          busy      <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
